// File: rtl/eship_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : eship_scheduler_if
// Purpose  : Setup/collision inputs and schedule outputs of the enemy-ship
//            wave scheduler, grouped for master (setup) / slave (scheduler).
// Revision : 1.0 - initial release
// ============================================================================
interface eship_scheduler_if #(
    parameter int NM = 16
);
    localparam int c_AW = (NM > 1) ? $clog2(NM) : 1;

    logic            Start;
    logic            WpWrEn;
    logic [c_AW-1:0] WpWrAddr;
    logic [9:0]      WpWrX;
    logic [9:0]      WpWrY;
    logic            WpWrFire;
    logic            EShipColl;

    logic [9:0]      ESchedCtr;
    logic [9:0]      ESchedX    [NM];
    logic [9:0]      ESchedY    [NM];
    logic            ESchedFire [NM];
    logic [9:0]      EShipInitialX;
    logic [9:0]      EShipInitialY;
    logic            WaveActive;
    logic            WaveDone;
    logic [2:0]      LivesLeft;

    modport master (
        output Start, WpWrEn, WpWrAddr, WpWrX, WpWrY, WpWrFire, EShipColl,
        input  ESchedCtr, ESchedX, ESchedY, ESchedFire,
        input  EShipInitialX, EShipInitialY, WaveActive, WaveDone, LivesLeft
    );

    modport slave (
        input  Start, WpWrEn, WpWrAddr, WpWrX, WpWrY, WpWrFire, EShipColl,
        output ESchedCtr, ESchedX, ESchedY, ESchedFire,
        output EShipInitialX, EShipInitialY, WaveActive, WaveDone, LivesLeft
    );
endinterface
`default_nettype wire

// File: rtl/eship_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : eship_scheduler
// Purpose  : Enemy-wave scheduler: waypoint table, per-waypoint pacing and
//            spawn / run / dead-respawn / done sequencing with a life count.
// Revision : 1.0 - initial release
// ============================================================================
module eship_scheduler #(
    parameter int NM             = 16,
    parameter int STEP_FRAMES    = 8,
    parameter int SPAWN_FRAMES   = 30,
    parameter int RESPAWN_FRAMES = 60,
    parameter int LIVES          = 3,
    parameter int LOOP           = 1,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 0
) (
    input  logic              frame_clk,
    input  logic              Reset,
    eship_scheduler_if.slave  bus
);

    localparam int c_AW   = (NM > 1) ? $clog2(NM) : 1;
    localparam int c_MAXA = (STEP_FRAMES > SPAWN_FRAMES) ? STEP_FRAMES : SPAWN_FRAMES;
    localparam int c_MAXF = (c_MAXA > RESPAWN_FRAMES) ? c_MAXA : RESPAWN_FRAMES;
    localparam int c_DW   = $clog2(c_MAXF) + 1;

    localparam logic [c_DW-1:0] c_STEP_LAST    = c_DW'(STEP_FRAMES - 1);
    localparam logic [c_DW-1:0] c_SPAWN_LAST   = c_DW'(SPAWN_FRAMES - 1);
    localparam logic [c_DW-1:0] c_RESPAWN_LAST = c_DW'(RESPAWN_FRAMES - 1);
    localparam logic [c_AW-1:0] c_LAST_IDX     = c_AW'(NM - 1);
    localparam logic [2:0]      c_LIVES        = 3'(LIVES);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SPAWN = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_DEAD  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [c_AW-1:0] r_ctr;
    logic [c_DW-1:0] r_dwell;
    logic [2:0]      r_lives;
    logic            r_waveActive;
    logic            r_waveDone;
    logic [9:0]      r_tabX    [NM];
    logic [9:0]      r_tabY    [NM];
    logic            r_tabFire [NM];

    logic [2:0]      w_stateNext;
    logic [c_AW-1:0] w_ctrNext;
    logic [c_DW-1:0] w_dwellNext;
    logic [2:0]      w_livesNext;
    logic            w_wrOk;

    always_comb begin
        w_stateNext = r_state;
        w_ctrNext   = r_ctr;
        w_dwellNext = r_dwell;
        w_livesNext = r_lives;
        w_wrOk      = bus.WpWrEn && ((r_state == c_IDLE) || (r_state == c_DONE));

        unique case (r_state)
            c_IDLE, c_DONE: begin
                if (bus.Start) begin
                    w_stateNext = c_SPAWN;
                    w_ctrNext   = '0;
                    w_dwellNext = '0;
                    w_livesNext = c_LIVES;
                end
            end
            c_SPAWN: begin
                if (r_dwell == c_SPAWN_LAST) begin
                    w_stateNext = c_RUN;
                    w_dwellNext = '0;
                end else begin
                    w_dwellNext = r_dwell + 1'b1;
                end
            end
            c_RUN: begin
                // A hit outranks a coincident waypoint step: the index freezes.
                if (bus.EShipColl) begin
                    w_livesNext = r_lives - 3'd1;
                    if (r_lives == 3'd1) begin
                        w_stateNext = c_DONE;
                    end else begin
                        w_stateNext = c_DEAD;
                        w_dwellNext = '0;
                    end
                end else if (r_dwell == c_STEP_LAST) begin
                    w_dwellNext = '0;
                    if (r_ctr == c_LAST_IDX) begin
                        if (LOOP != 0) begin
                            w_ctrNext = '0;
                        end else begin
                            w_stateNext = c_DONE;
                        end
                    end else begin
                        w_ctrNext = r_ctr + 1'b1;
                    end
                end else begin
                    w_dwellNext = r_dwell + 1'b1;
                end
            end
            c_DEAD: begin
                if (r_dwell == c_RESPAWN_LAST) begin
                    w_stateNext = c_RUN;
                    w_ctrNext   = '0;
                    w_dwellNext = '0;
                end else begin
                    w_dwellNext = r_dwell + 1'b1;
                end
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= c_IDLE;
            r_ctr        <= '0;
            r_dwell      <= '0;
            r_lives      <= c_LIVES;
            r_waveActive <= 1'b0;
            r_waveDone   <= 1'b0;
            for (int i = 0; i < NM; i++) begin
                r_tabX[i]    <= '0;
                r_tabY[i]    <= '0;
                r_tabFire[i] <= 1'b0;
            end
        end else begin
            r_state      <= w_stateNext;
            r_ctr        <= w_ctrNext;
            r_dwell      <= w_dwellNext;
            r_lives      <= w_livesNext;
            r_waveActive <= (w_stateNext == c_SPAWN) || (w_stateNext == c_RUN);
            r_waveDone   <= (w_stateNext == c_DONE);
            if (w_wrOk) begin
                r_tabX[bus.WpWrAddr]    <= bus.WpWrX;
                r_tabY[bus.WpWrAddr]    <= bus.WpWrY;
                r_tabFire[bus.WpWrAddr] <= bus.WpWrFire;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_tab
            assign bus.ESchedX[gi]    = r_tabX[gi];
            assign bus.ESchedY[gi]    = r_tabY[gi];
            assign bus.ESchedFire[gi] = r_tabFire[gi];
        end
    endgenerate

    assign bus.ESchedCtr     = 10'(r_ctr);
    assign bus.EShipInitialX = 10'(INIT_X);
    assign bus.EShipInitialY = 10'(INIT_Y);
    assign bus.WaveActive    = r_waveActive;
    assign bus.WaveDone      = r_waveDone;
    assign bus.LivesLeft     = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_eship_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_eship_scheduler
// Purpose  : Directed bench for eship_scheduler; a looping and a one-shot
//            instance share stimulus so wrap and end-of-wave can be compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eship_scheduler;

    logic r_clk = 1'b0;
    logic r_rst = 1'b1;
    int   r_checks   = 0;
    int   r_failures = 0;

    always #5 r_clk = ~r_clk;

    eship_scheduler_if #(.NM(16)) busL ();
    eship_scheduler_if #(.NM(16)) busO ();

    eship_scheduler #(.NM(16), .STEP_FRAMES(8), .SPAWN_FRAMES(30), .RESPAWN_FRAMES(60),
                      .LIVES(3), .LOOP(1), .INIT_X(320), .INIT_Y(0))
        u_dutLoop (.frame_clk(r_clk), .Reset(r_rst), .bus(busL));

    eship_scheduler #(.NM(16), .STEP_FRAMES(8), .SPAWN_FRAMES(30), .RESPAWN_FRAMES(60),
                      .LIVES(3), .LOOP(0), .INIT_X(320), .INIT_Y(0))
        u_dutOnce (.frame_clk(r_clk), .Reset(r_rst), .bus(busO));

    typedef struct {
        logic       start;
        logic       wrEn;
        logic [3:0] addr;
        logic [9:0] x;
        logic [9:0] y;
        logic       fire;
        logic       coll;
        int         expCtr;
        int         expActive;
        int         expLives;
        int         expX5;
        int         expFire5;
        int         expX3;
    } vec_t;

    vec_t vecs [4];

    task automatic drive(input logic start, input logic wrEn, input logic [3:0] addr,
                         input logic [9:0] x, input logic [9:0] y, input logic fire,
                         input logic coll);
        busL.Start = start; busL.WpWrEn = wrEn; busL.WpWrAddr = addr;
        busL.WpWrX = x; busL.WpWrY = y; busL.WpWrFire = fire; busL.EShipColl = coll;
        busO.Start = start; busO.WpWrEn = wrEn; busO.WpWrAddr = addr;
        busO.WpWrX = x; busO.WpWrY = y; busO.WpWrFire = fire; busO.EShipColl = coll;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        r_checks++;
        if (act != exp) begin
            r_failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nonZeroEntries(input int sel);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            if (sel == 0) begin
                if (busL.ESchedX[i] != 0 || busL.ESchedY[i] != 0 || busL.ESchedFire[i] != 0) n++;
            end else begin
                if (busO.ESchedX[i] != 0 || busO.ESchedY[i] != 0 || busO.ESchedFire[i] != 0) n++;
            end
        end
        return n;
    endfunction

    task automatic chkResetState(input string tag);
        chk({tag, "_ctr"},    int'(busL.ESchedCtr), 0);
        chk({tag, "_active"}, int'(busL.WaveActive), 0);
        chk({tag, "_done"},   int'(busL.WaveDone), 0);
        chk({tag, "_lives"},  int'(busL.LivesLeft), 3);
        chk({tag, "_tabL"},   nonZeroEntries(0), 0);
        chk({tag, "_tabO"},   nonZeroEntries(1), 0);
        chk({tag, "_livesO"}, int'(busO.LivesLeft), 3);
    endtask

    initial begin
        // Idle write, write+Start, ignored write and ignored Start/hit in SPAWN.
        vecs[0] = '{start:1'b0, wrEn:1'b1, addr:4'd5, x:10'd100, y:10'd200, fire:1'b1, coll:1'b0,
                    expCtr:0, expActive:0, expLives:3, expX5:100, expFire5:1, expX3:0};
        vecs[1] = '{start:1'b1, wrEn:1'b1, addr:4'd3, x:10'd7, y:10'd8, fire:1'b0, coll:1'b0,
                    expCtr:0, expActive:1, expLives:3, expX5:100, expFire5:1, expX3:7};
        vecs[2] = '{start:1'b0, wrEn:1'b1, addr:4'd5, x:10'd999, y:10'd999, fire:1'b0, coll:1'b0,
                    expCtr:0, expActive:1, expLives:3, expX5:100, expFire5:1, expX3:7};
        vecs[3] = '{start:1'b1, wrEn:1'b0, addr:4'd0, x:10'd0, y:10'd0, fire:1'b0, coll:1'b1,
                    expCtr:0, expActive:1, expLives:3, expX5:100, expFire5:1, expX3:7};

        idle();
        r_rst = 1'b1;
        ticks(2);
        chkResetState("reset");
        chk("initX", int'(busL.EShipInitialX), 320);
        chk("initY", int'(busL.EShipInitialY), 0);
        r_rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            drive(vecs[v].start, vecs[v].wrEn, vecs[v].addr, vecs[v].x, vecs[v].y,
                  vecs[v].fire, vecs[v].coll);
            ticks(1);
            chk($sformatf("v%0d_ctr", v),    int'(busL.ESchedCtr),      vecs[v].expCtr);
            chk($sformatf("v%0d_active", v), int'(busL.WaveActive),     vecs[v].expActive);
            chk($sformatf("v%0d_lives", v),  int'(busL.LivesLeft),      vecs[v].expLives);
            chk($sformatf("v%0d_x5", v),     int'(busL.ESchedX[5]),     vecs[v].expX5);
            chk($sformatf("v%0d_fire5", v),  int'(busL.ESchedFire[5]),  vecs[v].expFire5);
            chk($sformatf("v%0d_x3", v),     int'(busL.ESchedX[3]),     vecs[v].expX3);
        end
        idle();
        chk("y5", int'(busL.ESchedY[5]), 200);

        // Start edge is E0; now after E2. First step lands on E38.
        ticks(27);
        chk("spawnEnd_active", int'(busL.WaveActive), 1);
        chk("spawnEnd_ctr", int'(busL.ESchedCtr), 0);
        ticks(8);
        chk("e37_ctr", int'(busL.ESchedCtr), 0);
        ticks(1);
        chk("e38_ctr", int'(busL.ESchedCtr), 1);

        drive(1'b1, 1'b1, 4'd5, 10'd1, 10'd1, 1'b0, 1'b0);
        ticks(1);
        idle();
        chk("runStart_ctr", int'(busL.ESchedCtr), 1);
        chk("runWr_x5", int'(busL.ESchedX[5]), 100);
        chk("runWr_fire5", int'(busL.ESchedFire[5]), 1);

        // Hit exactly on the ctr=3 step edge (E62).
        ticks(22);
        chk("e61_ctr", int'(busL.ESchedCtr), 3);
        drive(1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        ticks(1);
        idle();
        chk("hit_ctr", int'(busL.ESchedCtr), 3);
        chk("hit_lives", int'(busL.LivesLeft), 2);
        chk("hit_active", int'(busL.WaveActive), 0);
        chk("hit_done", int'(busL.WaveDone), 0);

        ticks(7);
        drive(1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        ticks(1);
        idle();
        chk("deadHit_lives", int'(busL.LivesLeft), 2);
        ticks(51);
        chk("deadEnd_active", int'(busL.WaveActive), 0);
        chk("deadEnd_ctr", int'(busL.ESchedCtr), 3);
        ticks(1);
        chk("respawn_active", int'(busL.WaveActive), 1);
        chk("respawn_ctr", int'(busL.ESchedCtr), 0);

        // RUN re-entered at E122; index 15 dwell completes on E250.
        ticks(127);
        chk("e249_ctrL", int'(busL.ESchedCtr), 15);
        chk("e249_ctrO", int'(busO.ESchedCtr), 15);
        chk("e249_doneO", int'(busO.WaveDone), 0);
        ticks(1);
        chk("wrap_ctrL", int'(busL.ESchedCtr), 0);
        chk("wrap_activeL", int'(busL.WaveActive), 1);
        chk("end_ctrO", int'(busO.ESchedCtr), 15);
        chk("end_doneO", int'(busO.WaveDone), 1);
        chk("end_activeO", int'(busO.WaveActive), 0);

        drive(1'b0, 1'b1, 4'd7, 10'd55, 10'd66, 1'b1, 1'b0);
        ticks(1);
        idle();
        chk("doneWr_x7O", int'(busO.ESchedX[7]), 55);
        chk("runWr_x7L", int'(busL.ESchedX[7]), 0);

        drive(1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        ticks(1);
        idle();
        chk("hit2_livesL", int'(busL.LivesLeft), 1);
        chk("hit2_activeL", int'(busL.WaveActive), 0);
        chk("doneHit_livesO", int'(busO.LivesLeft), 2);
        ticks(59);
        chk("dead2_activeL", int'(busL.WaveActive), 0);
        ticks(1);
        chk("respawn2_activeL", int'(busL.WaveActive), 1);
        drive(1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        ticks(1);
        idle();
        chk("last_livesL", int'(busL.LivesLeft), 0);
        chk("last_doneL", int'(busL.WaveDone), 1);
        chk("last_activeL", int'(busL.WaveActive), 0);

        drive(1'b1, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        ticks(1);
        idle();
        chk("restart_livesL", int'(busL.LivesLeft), 3);
        chk("restart_activeL", int'(busL.WaveActive), 1);
        chk("restart_doneL", int'(busL.WaveDone), 0);
        chk("restart_doneO", int'(busO.WaveDone), 0);

        ticks(45);
        chk("preRst_ctr", int'(busL.ESchedCtr), 1);
        r_rst = 1'b1;
        ticks(1);
        chkResetState("midRst");
        r_rst = 1'b0;
        ticks(1);
        chk("postRst_active", int'(busL.WaveActive), 0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
